instr_reg_sched: RTL

INSTR_REG_SCHED -- requirements
Module: instr_reg_sched

---
 rtl/instr_reg_sched_if.sv | 57 +++++
 rtl/instr_reg_sched.sv | 102 ++++++++++
 2 files changed

// File: rtl/instr_reg_sched_if.sv
// rtl/instr_reg_sched_if.sv - instruction field types and the scheduler's bundled port interface
package instr_reg_sched_pkg;
    typedef enum logic [3:0] {NOP, ADD, SUB, AND, OR, XOR, SHL, SHR} opcode_t;
    typedef logic [15:0] operand_t;
    typedef logic [4:0]  address_t;
    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;
endpackage

interface instr_reg_sched_if;
    import instr_reg_sched_pkg::*;

    logic         req0_valid;
    logic         req0_ready;
    opcode_t      req0_opcode;
    operand_t     req0_op_a;
    operand_t     req0_op_b;
    logic         req1_valid;
    logic         req1_ready;
    opcode_t      req1_opcode;
    operand_t     req1_op_a;
    operand_t     req1_op_b;
    logic         load_en;
    address_t     write_pointer;
    address_t     read_pointer;
    opcode_t      opcode;
    operand_t     operand_a;
    operand_t     operand_b;
    instruction_t instruction_word;
    logic         out_valid;
    logic         out_ready;
    instruction_t out_word;
    logic [5:0]   count;
    logic         full;
    logic         empty;

    // scheduler side
    modport slave (
        input  req0_valid, req0_opcode, req0_op_a, req0_op_b,
        input  req1_valid, req1_opcode, req1_op_a, req1_op_b,
        input  instruction_word, out_ready,
        output req0_ready, req1_ready, load_en, write_pointer, read_pointer,
        output opcode, operand_a, operand_b, out_valid, out_word, count, full, empty
    );

    // requesters, register file and consumer side
    modport master (
        output req0_valid, req0_opcode, req0_op_a, req0_op_b,
        output req1_valid, req1_opcode, req1_op_a, req1_op_b,
        output instruction_word, out_ready,
        input  req0_ready, req1_ready, load_en, write_pointer, read_pointer,
        input  opcode, operand_a, operand_b, out_valid, out_word, count, full, empty
    );
endinterface

// File: rtl/instr_reg_sched.sv
// rtl/instr_reg_sched.sv - two-requester circular-queue scheduler over an external instruction register
// Define IR_SCHED_RR_EN for round-robin arbitration; default is fixed priority to req0.
module instr_reg_sched
    import instr_reg_sched_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_reg_sched_if.slave   bus
);

    typedef enum logic {PRI_REQ0, PRI_REQ1} pri_e;

    localparam logic [6:0] DEPTH_W = 7'(DEPTH);
    localparam address_t   LAST    = address_t'(DEPTH - 1);

    pri_e       pri_q, pri_d;
    address_t   tail_q, head_q, wp_q;
    logic [5:0] count_q;
    logic       load_q;
    opcode_t    opc_q;
    operand_t   a_q, b_q;
    logic       space, grant0, grant1, accept, pop;

    function automatic address_t ptr_inc(input address_t p);
        if (p == LAST) return '0;
        return p + 5'd1;
    endfunction

    // the uncommitted write already owns a slot, so it counts against capacity
    assign space  = ({1'b0, count_q} + {6'd0, load_q}) < DEPTH_W;
    assign pop    = (count_q != 6'd0) && bus.out_ready;
    assign accept = grant0 || grant1;

    always_comb begin
        pri_d  = pri_q;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n && space) begin
`ifdef IR_SCHED_RR_EN
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = (pri_q == PRI_REQ0);
                grant1 = (pri_q == PRI_REQ1);
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
            if (grant0) pri_d = PRI_REQ1;
            else if (grant1) pri_d = PRI_REQ0;
`else
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid && !bus.req0_valid;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pri_q   <= PRI_REQ0;
            tail_q  <= '0;
            head_q  <= '0;
            wp_q    <= '0;
            count_q <= '0;
            load_q  <= 1'b0;
            opc_q   <= NOP;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            pri_q  <= pri_d;
            load_q <= accept;
            if (accept) begin
                wp_q   <= tail_q;
                tail_q <= ptr_inc(tail_q);
                opc_q  <= grant0 ? bus.req0_opcode : bus.req1_opcode;
                a_q    <= grant0 ? bus.req0_op_a   : bus.req1_op_a;
                b_q    <= grant0 ? bus.req0_op_b   : bus.req1_op_b;
            end
            if (pop) head_q <= ptr_inc(head_q);
            case ({load_q, pop})
                2'b10:   count_q <= count_q + 6'd1;
                2'b01:   count_q <= count_q - 6'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.req0_ready    = grant0;
    assign bus.req1_ready    = grant1;
    assign bus.load_en       = load_q;
    assign bus.write_pointer = wp_q;
    assign bus.read_pointer  = head_q;
    assign bus.opcode        = opc_q;
    assign bus.operand_a     = a_q;
    assign bus.operand_b     = b_q;
    assign bus.out_valid     = (count_q != 6'd0);
    assign bus.out_word      = bus.instruction_word;
    assign bus.count         = count_q;
    assign bus.full          = (count_q == DEPTH_W[5:0]);
    assign bus.empty         = (count_q == 6'd0);

endmodule
